// File: rtl/spi_xfer_queue_if.sv
// Stream and master-side bundle for spi_xfer_queue.
//   tx_data/tx_valid/tx_ready : host -> queue outbound word stream
//   rx_data/rx_valid/rx_ready : queue -> host received word stream
//   timeout_err, idle         : queue status to host
//   m_start/m_data_in         : queue -> SPI master launch
//   m_done/m_data_out         : SPI master -> queue completion
// The slave modport is the queue's view; the master modport is the view of
// whatever sits around it (host plus SPI master).
interface spi_xfer_queue_if #(
  parameter int DATA_LENGTH = 8
);
  logic [DATA_LENGTH-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [DATA_LENGTH-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   timeout_err;
  logic                   idle;
  logic                   m_start;
  logic [DATA_LENGTH-1:0] m_data_in;
  logic                   m_done;
  logic [DATA_LENGTH-1:0] m_data_out;

  modport slave (
    input  tx_data, tx_valid, rx_ready, m_done, m_data_out,
    output tx_ready, rx_data, rx_valid, timeout_err, idle, m_start, m_data_in
  );

  modport master (
    output tx_data, tx_valid, rx_ready, m_done, m_data_out,
    input  tx_ready, rx_data, rx_valid, timeout_err, idle, m_start, m_data_in
  );
endinterface

// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: transaction sequencer in front of an SPI master.
// Outbound words are buffered in a TX FIFO; each one launches a single master
// transfer and the word returned by the master is pushed into an RX FIFO.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : spi_xfer_queue_if.slave (host tx/rx streams, status, master link)
module spi_xfer_queue #(
  parameter int DATA_LENGTH = 8,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int TIMEOUT     = 1024
) (
  input logic             clk,
  input logic             rst,
  spi_xfer_queue_if.slave bus
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, STORE} state_t;

  state_t state, state_next;

  logic [DATA_LENGTH-1:0] tx_mem [TX_DEPTH];
  logic [DATA_LENGTH-1:0] rx_mem [RX_DEPTH];
  logic [TXA:0]           tx_wr, tx_rd;
  logic [RXA:0]           rx_wr, rx_rd, rx_count;
  logic                   tx_full, tx_empty, tx_push, tx_pop;
  logic                   rx_full, rx_empty, rx_push, rx_pop;
  logic                   done_q, done_rise, timer_last;
  logic [TW-1:0]          timer;
  logic [DATA_LENGTH-1:0] rx_word;

  // FIFO status from extended pointers: MSB differs with equal low bits => full
  assign tx_full  = (tx_wr[TXA] != tx_rd[TXA]) && (tx_wr[TXA-1:0] == tx_rd[TXA-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign rx_full  = (rx_wr[RXA] != rx_rd[RXA]) && (rx_wr[RXA-1:0] == rx_rd[RXA-1:0]);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_count = rx_wr - rx_rd;

  assign tx_push = bus.tx_valid & ~tx_full;
  assign tx_pop  = (state == LAUNCH);
  assign rx_push = (state == STORE);
  assign rx_pop  = ~rx_empty & bus.rx_ready;

  assign done_rise  = bus.m_done & ~done_q;
  assign timer_last = (timer == TW'(TIMEOUT - 1));

  assign bus.tx_ready = ~tx_full;
  assign bus.rx_valid = ~rx_empty;
  assign bus.rx_data  = rx_empty ? '0 : rx_mem[rx_rd[RXA-1:0]];
  assign bus.idle     = (state == IDLE) && tx_empty;

  // Next state. Launch only when a free RX slot exists; nothing is in flight
  // while in IDLE, so the current RX occupancy is the whole reservation and
  // the RX FIFO can never overflow.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!tx_empty && (rx_count < (RXA+1)'(RX_DEPTH))) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (done_rise)       state_next = STORE;
        else if (timer_last) state_next = IDLE;
      end
      STORE:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Control registers. m_start is high exactly while in LAUNCH; m_data_in
  // is loaded on entry to LAUNCH so the master sees it with the pulse and
  // it stays put until the next launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      done_q          <= 1'b0;
      timer           <= '0;
      bus.m_start     <= 1'b0;
      bus.m_data_in   <= '0;
      bus.timeout_err <= 1'b0;
      tx_wr           <= '0;
      tx_rd           <= '0;
      rx_wr           <= '0;
      rx_rd           <= '0;
    end else begin
      state       <= state_next;
      done_q      <= bus.m_done;
      bus.m_start <= (state_next == LAUNCH);
      if (state == IDLE && state_next == LAUNCH)
        bus.m_data_in <= tx_mem[tx_rd[TXA-1:0]];
      if (state == LAUNCH)
        timer <= '0;
      else if (state == WAIT_DONE)
        timer <= timer + 1'b1;
      // A done_rise coinciding with the last timer cycle takes precedence.
      if (state == WAIT_DONE && !done_rise && timer_last)
        bus.timeout_err <= 1'b1;
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
    end
  end

  // Data storage: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[TXA-1:0]] <= bus.tx_data;
    if (state == WAIT_DONE && done_rise) rx_word <= bus.m_data_out;
    if (rx_push) rx_mem[rx_wr[RXA-1:0]] <= rx_word;
  end
endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue with a behavioural SPI master model.
module tb_spi_xfer_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  spi_xfer_queue_if #(.DATA_LENGTH(8)) bus ();

  spi_xfer_queue #(
    .DATA_LENGTH(8), .TX_DEPTH(4), .RX_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Master model: answers each m_start after 3 cycles, either echoing the
  // launched word or returning 0x3C. sticky keeps done high until the next
  // start; dead never answers; inject_req forces one late done edge.
  logic       fixed_mode = 1'b0;
  logic       sticky = 1'b0;
  logic       dead = 1'b0;
  int         inject_req = 0;
  int         inject_ack = 0;
  int         launch_cnt = 0;
  logic [7:0] launch_data [64];
  int         mcnt = 0;
  logic [7:0] captured = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      bus.m_done     = 1'b0;
      bus.m_data_out = 8'h00;
      mcnt           = 0;
    end else if (bus.m_start) begin
      if (launch_cnt < 64) launch_data[launch_cnt] = bus.m_data_in;
      launch_cnt++;
      captured   = bus.m_data_in;
      mcnt       = 3;
      bus.m_done = 1'b0;
    end else if (inject_req != inject_ack) begin
      inject_ack     = inject_req;
      bus.m_done     = 1'b1;
      bus.m_data_out = 8'h99;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0 && !dead) begin
        bus.m_done     = 1'b1;
        bus.m_data_out = fixed_mode ? 8'h3C : captured;
      end
    end else if (!sticky) begin
      bus.m_done = 1'b0;
    end
  end

  logic [7:0] rx_log [16];
  int         rx_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Hold tx_valid until the word is accepted (bounded).
  task automatic push(input logic [7:0] d);
    bit ok = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    for (int i = 0; i < 200; i++) begin
      if (bus.tx_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.tx_valid = 1'b0;
    if (!ok) chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic collect(input int ncyc);
    rx_cnt = 0;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (bus.rx_valid && rx_cnt < 16) begin
        rx_log[rx_cnt] = bus.rx_data;
        rx_cnt++;
      end
      tick();
    end
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.m_start) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
    chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'h00);
    chk({tag, "_idle"}, 32'(bus.idle), 32'd1);
    chk({tag, "_m_start"}, 32'(bus.m_start), 32'd0);
    chk({tag, "_m_data_in"}, 32'(bus.m_data_in), 32'h00);
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  initial begin
    int base;
    bit seen;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    chk_reset_values("rst");

    // Single transfer with exact launch latency: handshake cycle N, start N+2.
    fixed_mode   = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    tick();
    bus.tx_valid = 1'b0;
    chk("single_no_start_n1", 32'(bus.m_start), 32'd0);
    tick();
    chk("single_start_n2", 32'(bus.m_start), 32'd1);
    chk("single_m_data_in", 32'(bus.m_data_in), 32'hA5);
    tick();
    chk("single_start_pulse", 32'(bus.m_start), 32'd0);
    chk("single_data_held", 32'(bus.m_data_in), 32'hA5);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rx_valid) begin seen = 1'b1; break; end
      tick();
    end
    chk("single_rx_arrives", 32'(seen), 32'd1);
    chk("single_rx_data", 32'(bus.rx_data), 32'h3C);
    chk("single_launches", 32'(launch_cnt), 32'd1);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    chk("single_rx_drained", 32'(bus.rx_valid), 32'd0);
    chk("single_idle", 32'(bus.idle), 32'd1);
    fixed_mode = 1'b0;

    // Burst of four, echoed back in order.
    base = launch_cnt;
    for (int i = 1; i <= 4; i++) push(8'(i));
    collect(80);
    chk("burst_rx_count", 32'(rx_cnt), 32'd4);
    chk("burst_launches", 32'(launch_cnt - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_launch_%0d", i), 32'(launch_data[base+i]), 32'(i + 1));
      chk($sformatf("burst_rx_%0d", i), 32'(rx_log[i]), 32'(i + 1));
    end

    // RX backpressure: 6 words with host stalled, exactly 4 launch.
    base = launch_cnt;
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    for (int i = 0; i < 60; i++) tick();
    chk("bp_launches_parked", 32'(launch_cnt - base), 32'd4);
    chk("bp_rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("bp_rx_head", 32'(bus.rx_data), 32'h11);
    chk("bp_not_idle", 32'(bus.idle), 32'd0);
    chk("bp_m_start_low", 32'(bus.m_start), 32'd0);
    // Two more words fill the 4-deep TX FIFO while the FSM stays parked.
    push(8'h17);
    push(8'h18);
    chk("bp_tx_full", 32'(bus.tx_ready), 32'd0);
    collect(150);
    chk("bp_rx_count", 32'(rx_cnt), 32'd8);
    chk("bp_launches_total", 32'(launch_cnt - base), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bp_rx_%0d", i), 32'(rx_log[i]), 32'h11 + 32'(i));
    chk("bp_tx_ready_back", 32'(bus.tx_ready), 32'd1);

    // Sticky done: one RX word per transfer even with done held high.
    sticky = 1'b1;
    push(8'h21);
    push(8'h22);
    collect(60);
    chk("sticky_rx_count", 32'(rx_cnt), 32'd2);
    chk("sticky_rx_0", 32'(rx_log[0]), 32'h21);
    chk("sticky_rx_1", 32'(rx_log[1]), 32'h22);
    chk("sticky_done_high", 32'(bus.m_done), 32'd1);
    sticky = 1'b0;
    tick(); tick();

    // Timeout: WAIT_DONE occupies 16 cycles after LAUNCH, error follows.
    dead = 1'b1;
    push(8'h31);
    wait_start("to_start_seen");
    for (int i = 0; i < 16; i++) tick();
    chk("to_err_not_yet", 32'(bus.timeout_err), 32'd0);
    tick();
    chk("to_err_set", 32'(bus.timeout_err), 32'd1);
    chk("to_no_rx", 32'(bus.rx_valid), 32'd0);
    chk("to_idle", 32'(bus.idle), 32'd1);
    dead = 1'b0;
    push(8'h32);
    collect(40);
    chk("to_next_rx_count", 32'(rx_cnt), 32'd1);
    chk("to_next_rx_data", 32'(rx_log[0]), 32'h32);
    chk("to_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset during WAIT_DONE with two words still queued.
    dead = 1'b1;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    tick(); tick(); tick();
    chk("rstmid_busy", 32'(bus.idle), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_values("rstmid");
    base = launch_cnt;
    dead = 1'b0;
    inject_req++;
    for (int i = 0; i < 12; i++) tick();
    chk("rstmid_late_done_seen", 32'(inject_ack), 32'(inject_req));
    chk("rstmid_no_rx", 32'(bus.rx_valid), 32'd0);
    chk("rstmid_no_launch", 32'(launch_cnt - base), 32'd0);
    chk("rstmid_still_idle", 32'(bus.idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
